// File: rtl/cons_bus_pkg.sv
// Shared types for the con_1..con_3 pad scheduler: FSM states, grant owner,
// and the turnaround counter width.
package cons_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TURN_DRIVE,
        ST_DRAIN,
        ST_TURN_RELEASE
    } cbs_state_e;

    typedef enum logic {
        LOAD,
        DRAIN
    } grant_e;

    localparam int TURN_W = 3;

endpackage

// File: rtl/beat_down_counter.sv
// Remaining-beat down counter shared by the load and drain transactions.
// `last` flags the final beat so the owner can close the transaction.
module beat_down_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] rem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg <= '0;
        end else if (load) begin
            rem_reg <= load_value;
        end else if (dec && (rem_reg != '0)) begin
            rem_reg <= rem_reg - W'(1);
        end
    end

    assign last = (rem_reg == W'(1));

endmodule

// File: rtl/cons_bus_scheduler.sv
// Arbitrates the shared con pads between input load and output drain,
// running the valid/ready handshake and inserting direction-change gaps.
module cons_bus_scheduler
    import cons_bus_pkg::*;
#(
    parameter int MAX_BEATS  = 64,
    parameter int TURNAROUND = 1,
    parameter int BEAT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              arst_in,
    input  logic              load_req,
    input  logic [BEAT_W-1:0] load_beats,
    output logic              load_grant,
    output logic              load_beat,
    output logic              load_done,
    input  logic              drain_req,
    input  logic [BEAT_W-1:0] drain_beats,
    output logic              drain_grant,
    output logic              drain_beat,
    output logic              drain_done,
    input  logic              con_valid,
    output logic              con_ready,
    output logic              output_valid,
    input  logic              out_ready,
    output logic              driving_cons,
    output logic              busy
);

    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

    cbs_state_e        state_reg, state_next;
    logic [TURN_W-1:0] turn_reg, turn_next;
    grant_e            last_grant_reg, last_grant_next;

    logic              cnt_load;
    logic [BEAT_W-1:0] cnt_value;
    logic              cnt_last;
    logic              load_ok, drain_ok, pick_load;

    beat_down_counter #(.W(BEAT_W)) u_beats (
        .clk        (clk),
        .rst        (arst_in),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (load_beat | drain_beat),
        .last       (cnt_last)
    );

    // Outputs decode from state only, so reset clears them (and releases
    // the pads) the instant arst_in rises.
    assign busy         = (state_reg != ST_IDLE);
    assign load_grant   = (state_reg == ST_LOAD);
    assign con_ready    = (state_reg == ST_LOAD);
    assign load_beat    = con_valid & con_ready;
    assign load_done    = load_beat & cnt_last;
    assign drain_grant  = (state_reg == ST_TURN_DRIVE) || (state_reg == ST_DRAIN);
    assign driving_cons = (state_reg == ST_DRAIN);
    assign output_valid = (state_reg == ST_DRAIN);
    assign drain_beat   = output_valid & out_ready;
    assign drain_done   = drain_beat & cnt_last;

    assign load_ok   = load_req && (load_beats != '0);
    assign drain_ok  = drain_req && (drain_beats != '0);
    assign pick_load = load_ok && (!drain_ok || (last_grant_reg == DRAIN));

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_reg      <= ST_IDLE;
            turn_reg       <= '0;
            last_grant_reg <= DRAIN;
        end else begin
            state_reg      <= state_next;
            turn_reg       <= turn_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        turn_next       = turn_reg;
        last_grant_next = last_grant_reg;
        cnt_load        = 1'b0;
        cnt_value       = load_beats;
        case (state_reg)
            ST_IDLE: begin
                if (pick_load) begin
                    state_next      = ST_LOAD;
                    cnt_load        = 1'b1;
                    cnt_value       = load_beats;
                    last_grant_next = LOAD;
                end else if (drain_ok) begin
                    state_next      = ST_TURN_DRIVE;
                    cnt_load        = 1'b1;
                    cnt_value       = drain_beats;
                    turn_next       = '0;
                    last_grant_next = DRAIN;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TURN_DRIVE: begin
                if (turn_reg == TURN_LAST) begin
                    state_next = ST_DRAIN;
                    turn_next  = '0;
                end else begin
                    turn_next = turn_reg + TURN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_next = ST_TURN_RELEASE;
                    turn_next  = '0;
                end
            end
            ST_TURN_RELEASE: begin
                if (turn_reg == TURN_LAST) begin
                    state_next = ST_IDLE;
                    turn_next  = '0;
                end else begin
                    turn_next = turn_reg + TURN_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                turn_next  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cons_bus_scheduler.sv
// Bench for cons_bus_scheduler: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cons_bus_scheduler;

    localparam int MAX_BEATS = 64;
    localparam int TURN      = 1;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    logic              clk = 1'b0;
    logic              arst_in;
    logic              load_req, drain_req, con_valid, out_ready;
    logic [BEAT_W-1:0] load_beats, drain_beats;
    logic              load_grant, load_beat, load_done;
    logic              drain_grant, drain_beat, drain_done;
    logic              con_ready, output_valid, driving_cons, busy;

    cons_bus_scheduler #(.MAX_BEATS(MAX_BEATS), .TURNAROUND(TURN)) dut (
        .clk(clk), .arst_in(arst_in),
        .load_req(load_req), .load_beats(load_beats),
        .load_grant(load_grant), .load_beat(load_beat), .load_done(load_done),
        .drain_req(drain_req), .drain_beats(drain_beats),
        .drain_grant(drain_grant), .drain_beat(drain_beat), .drain_done(drain_done),
        .con_valid(con_valid), .con_ready(con_ready),
        .output_valid(output_valid), .out_ready(out_ready),
        .driving_cons(driving_cons), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: owner 0 none, 1 load, 2 drain. A drain walks through
    // pre-turn cycles, then its beats, then post-turn cycles.
    int m_owner, m_rem, m_pre, m_post, cyc;
    bit m_last_load;

    always @(posedge clk or posedge arst_in) begin
        bit lok, dok;
        if (arst_in) begin
            m_owner = 0; m_rem = 0; m_pre = 0; m_post = 0;
            m_last_load = 1'b0; cyc = 0;
        end else begin
            cyc++;
            case (m_owner)
                0: begin
                    lok = load_req && (load_beats != 0);
                    dok = drain_req && (drain_beats != 0);
                    if (lok && (!dok || !m_last_load)) begin
                        m_owner = 1; m_rem = load_beats; m_last_load = 1'b1;
                    end else if (dok) begin
                        m_owner = 2; m_rem = drain_beats;
                        m_pre = TURN; m_post = TURN; m_last_load = 1'b0;
                    end
                end
                1: if (con_valid) begin
                    m_rem--;
                    if (m_rem == 0) m_owner = 0;
                end
                default: begin
                    if (m_pre > 0) m_pre--;
                    else if (m_rem > 0) begin
                        if (out_ready) m_rem--;
                    end else begin
                        m_post--;
                        if (m_post == 0) m_owner = 0;
                    end
                end
            endcase
        end
    end

    // Per-scenario statistics
    int n_busy, n_lg_cyc, n_turn_drive, n_drive, n_release, n_overlap;
    int n_load_beat, n_load_done, n_drain_beat, n_drain_done;
    int n_grants, first_lg_cyc, last_ld_cyc, busy_at5;
    byte grant_log [8];
    logic prev_lg = 1'b0, prev_dg = 1'b0;

    task automatic clear_stats();
        n_busy = 0; n_lg_cyc = 0; n_turn_drive = 0; n_drive = 0; n_release = 0;
        n_overlap = 0; n_load_beat = 0; n_load_done = 0; n_drain_beat = 0;
        n_drain_done = 0; n_grants = 0; first_lg_cyc = -1; last_ld_cyc = -1;
        busy_at5 = -1;
    endtask

    always @(negedge clk) begin
        bit e_lg, e_lb, e_ld, e_dg, e_dc, e_db, e_dd, e_busy;
        e_lg   = (m_owner == 1);
        e_lb   = e_lg && con_valid;
        e_ld   = e_lb && (m_rem == 1);
        e_dg   = (m_owner == 2) && ((m_pre > 0) || (m_rem > 0));
        e_dc   = (m_owner == 2) && (m_pre == 0) && (m_rem > 0);
        e_db   = e_dc && out_ready;
        e_dd   = e_db && (m_rem == 1);
        e_busy = (m_owner != 0);
        check("load_grant",   load_grant,   e_lg);
        check("con_ready",    con_ready,    e_lg);
        check("load_beat",    load_beat,    e_lb);
        check("load_done",    load_done,    e_ld);
        check("drain_grant",  drain_grant,  e_dg);
        check("driving_cons", driving_cons, e_dc);
        check("output_valid", output_valid, e_dc);
        check("drain_beat",   drain_beat,   e_db);
        check("drain_done",   drain_done,   e_dd);
        check("busy",         busy,         e_busy);

        if (busy) n_busy++;
        if (load_grant) n_lg_cyc++;
        if (drain_grant && !driving_cons) n_turn_drive++;
        if (driving_cons) n_drive++;
        if (busy && !load_grant && !drain_grant) n_release++;
        if (con_ready && driving_cons) n_overlap++;
        if (load_beat) n_load_beat++;
        if (load_done) begin n_load_done++; last_ld_cyc = cyc; end
        if (drain_beat) n_drain_beat++;
        if (drain_done) n_drain_done++;
        if (load_grant && first_lg_cyc < 0) first_lg_cyc = cyc;
        if (cyc == 5) busy_at5 = busy;
        if (load_grant && !prev_lg && n_grants < 8) begin grant_log[n_grants] = "L"; n_grants++; end
        if (drain_grant && !prev_dg && n_grants < 8) begin grant_log[n_grants] = "D"; n_grants++; end
        prev_lg = load_grant;
        prev_dg = drain_grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin tick(); k++; end
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        #2 arst_in = 1'b1;
        tick(); tick();
        arst_in = 1'b0;
    endtask

    initial begin
        arst_in = 1'b1;
        load_req = 0; drain_req = 0; con_valid = 0; out_ready = 0;
        load_beats = '0; drain_beats = '0;
        clear_stats();

        // Load of 4 beats straight out of reset
        load_req = 1; load_beats = 4; con_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_driving", driving_cons, 0);
        arst_in = 1'b0;
        clear_stats();
        repeat (4) tick();
        load_req = 0;
        repeat (2) tick();
        check("t1_grant_cyc", first_lg_cyc, 1);
        check("t1_done_cyc", last_ld_cyc, 4);
        check("t1_beats", n_load_beat, 4);
        check("t1_dones", n_load_done, 1);
        check("t1_busy_at5", busy_at5, 0);
        con_valid = 0;

        // Drain of 3 with a 2-cycle sink stall; request dropped in TURN_DRIVE
        clear_stats();
        drain_req = 1; drain_beats = 3;
        tick();
        drain_req = 0;
        tick(); out_ready = 1;
        tick(); out_ready = 0;
        tick(); out_ready = 0;
        tick(); out_ready = 1;
        tick(); out_ready = 1;
        tick(); out_ready = 0;
        wait_idle(20);
        check("t2_turn_drive", n_turn_drive, 1);
        check("t2_drive_cyc", n_drive, 5);
        check("t2_beats", n_drain_beat, 3);
        check("t2_dones", n_drain_done, 1);
        check("t2_release", n_release, 1);

        // Round-robin with both requests held from reset
        load_req = 1; drain_req = 1; load_beats = 2; drain_beats = 2;
        con_valid = 1; out_ready = 1;
        do_reset();
        clear_stats();
        for (int i = 0; i < 200 && n_grants < 4; i++) tick();
        load_req = 0; drain_req = 0;
        wait_idle(20);
        check("t3_grant_count_ge4", (n_grants >= 4) ? 1 : 0, 1);
        check("t3_order0", grant_log[0], "L");
        check("t3_order1", grant_log[1], "D");
        check("t3_order2", grant_log[2], "L");
        check("t3_order3", grant_log[3], "D");
        check("t3_overlap", n_overlap, 0);

        // Zero-beat request ignored, then a full 64-beat load at half rate
        clear_stats();
        con_valid = 0; out_ready = 0;
        load_req = 1; load_beats = 0;
        repeat (5) tick();
        check("t4_zero_busy", n_busy, 0);
        load_beats = 64; con_valid = 1;
        for (int i = 0; i < 140; i++) begin
            tick();
            load_req = 0;
            con_valid = ~con_valid;
        end
        con_valid = 0;
        wait_idle(10);
        check("t4_beats", n_load_beat, 64);
        check("t4_dones", n_load_done, 1);
        check("t4_grant_cyc", n_lg_cyc, 128);

        // Asynchronous reset during drain beat 2 of 5
        clear_stats();
        drain_req = 1; drain_beats = 5; out_ready = 1;
        tick();
        drain_req = 0;
        tick();
        tick();
        check("t5_driving_before", driving_cons, 1);
        #2 arst_in = 1'b1;
        #1;
        check("t5_async_driving", driving_cons, 0);
        check("t5_async_ovalid", output_valid, 0);
        check("t5_async_dgrant", drain_grant, 0);
        tick(); tick();
        arst_in = 1'b0;
        drain_req = 1; drain_beats = 1;
        tick();
        drain_req = 0;
        wait_idle(20);
        check("t5_dones", n_drain_done, 1);
        check("t5_beats", n_drain_beat, 2);

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            load_req    = ($urandom_range(0, 3) != 0);
            drain_req   = ($urandom_range(0, 2) == 0);
            load_beats  = ($urandom_range(0, 19) == 0) ? BEAT_W'($urandom_range(0, 64))
                                                       : BEAT_W'($urandom_range(0, 6));
            drain_beats = ($urandom_range(0, 19) == 0) ? BEAT_W'($urandom_range(0, 64))
                                                       : BEAT_W'($urandom_range(0, 6));
            con_valid   = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        load_req = 0; drain_req = 0; con_valid = 1; out_ready = 1;
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
